// File: rtl/boss_shot_scheduler.sv
// Boss attack timing: cooldown, charge telegraph, then a burst of shots.
// Also drives the direction-reversal pulse and axis select for movement.
module boss_shot_scheduler #(
   parameter int          PERIOD_MIN_FRAMES = 20,
   parameter int          PERIOD_RANGE_BITS = 5,
   parameter int          CHARGE_FRAMES     = 8,
   parameter int          BURST_LEN         = 3,
   parameter int          BURST_GAP_FRAMES  = 4,
   parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       enable,
   input  logic       boss_hit,
   input  logic       shot_ready,
   output logic       shot_pulse,
   output logic       switch_direction_pulse,
   output logic       random_axis,
   output logic       charging,
   output logic [2:0] burst_count
);

   localparam int CW = 16;

   typedef enum logic [2:0] {
      IDLE,
      COOLDOWN,
      CHARGE,
      FIRE,
      GAP
   } state_t;

   state_t          state;
   state_t          nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [CW-1:0]   cool_len;
   logic [2:0]      bc_nxt;
   logic [2:0]      bc_inc;
   logic [15:0]     lfsr;
   logic            lfsr_fb;
   logic            expired;
   logic            shot;
   logic            first_shot;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   assign cool_len = CW'(PERIOD_MIN_FRAMES)
                   + CW'(lfsr[PERIOD_RANGE_BITS-1:0]);

   // The frame in which the counter was loaded never reaches here,
   // so only startOfFrame pulses seen after entry count down.
   assign expired = startOfFrame && (cnt <= CW'(1));

   assign shot       = enable && (state == FIRE) && shot_ready;
   assign first_shot = shot && (burst_count == 3'd0);
   assign bc_inc     = burst_count + 3'd1;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= IDLE;
         cnt         <= '0;
         burst_count <= '0;
         lfsr        <= LFSR_SEED;
         random_axis <= 1'b0;
         charging    <= 1'b0;
      end else begin
         state       <= nxt;
         cnt         <= cnt_nxt;
         burst_count <= bc_nxt;
         charging    <= (nxt == CHARGE);
         if (startOfFrame)
            lfsr <= {lfsr[14:0], lfsr_fb};
         if (first_shot)
            random_axis <= lfsr[0];
      end
   end

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      bc_nxt  = burst_count;
      if (startOfFrame && (cnt != '0))
         cnt_nxt = cnt - CW'(1);
      if (!enable) begin
         nxt     = IDLE;
         cnt_nxt = '0;
         bc_nxt  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               nxt     = COOLDOWN;
               cnt_nxt = cool_len;
            end
            COOLDOWN: begin
               if (expired) begin
                  nxt     = CHARGE;
                  cnt_nxt = CW'(CHARGE_FRAMES);
               end
            end
            CHARGE: begin
               if (boss_hit) begin
                  nxt     = COOLDOWN;
                  cnt_nxt = cool_len;
               end else if (expired) begin
                  nxt = FIRE;
               end
            end
            FIRE: begin
               if (shot_ready) begin
                  if (bc_inc == 3'(BURST_LEN)) begin
                     nxt     = COOLDOWN;
                     cnt_nxt = cool_len;
                     bc_nxt  = '0;
                  end else begin
                     nxt     = GAP;
                     cnt_nxt = CW'(BURST_GAP_FRAMES);
                     bc_nxt  = bc_inc;
                  end
               end
            end
            GAP: begin
               if (expired)
                  nxt = FIRE;
            end
            default: nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      shot_pulse             = shot;
      switch_direction_pulse = first_shot;
   end

endmodule

// File: tb/tb_boss_shot_scheduler.sv
// Randomized and scenario bench for boss_shot_scheduler.
// A frame-level reference model predicts every output each cycle.
module tb_boss_shot_scheduler;

   localparam int          PMIN = 20;
   localparam int          PRB  = 5;
   localparam int          CF   = 8;
   localparam int          BL   = 3;
   localparam int          GAPF = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk;
   logic       resetN;
   logic       sof;
   logic       enable;
   logic       boss_hit;
   logic       shot_ready;
   logic       shot_pulse;
   logic       switch_direction_pulse;
   logic       random_axis;
   logic       charging;
   logic [2:0] burst_count;

   int total = 0;
   int bad   = 0;

   boss_shot_scheduler #(
      .PERIOD_MIN_FRAMES(PMIN),
      .PERIOD_RANGE_BITS(PRB),
      .CHARGE_FRAMES(CF),
      .BURST_LEN(BL),
      .BURST_GAP_FRAMES(GAPF),
      .LFSR_SEED(SEED)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .startOfFrame(sof),
      .enable(enable),
      .boss_hit(boss_hit),
      .shot_ready(shot_ready),
      .shot_pulse(shot_pulse),
      .switch_direction_pulse(switch_direction_pulse),
      .random_axis(random_axis),
      .charging(charging),
      .burst_count(burst_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [6:0] obs_v;
   logic [6:0] exp_v;
   assign obs_v = {shot_pulse, switch_direction_pulse, charging,
                   random_axis, burst_count};

   typedef enum int {M_IDLE, M_COOL, M_CHG, M_FIRE, M_GAP} mph_t;

   mph_t        m_ph;
   int          m_seen;
   int          m_need;
   int          m_shots;
   logic [15:0] m_lfsr;
   logic        m_axis;

   function automatic logic [15:0] lfsr_step(logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   function automatic int cool_frames(logic [15:0] v);
      return PMIN + (int'(v) % (1 << PRB));
   endfunction

   task automatic m_reset();
      m_ph    = M_IDLE;
      m_seen  = 0;
      m_need  = 0;
      m_shots = 0;
      m_lfsr  = SEED;
      m_axis  = 1'b0;
   endtask

   task automatic m_enter(mph_t p, int need);
      m_ph   = p;
      m_need = need;
      m_seen = 0;
   endtask

   // Counts a frame in a timed phase; true once the wait is over.
   function automatic bit frame_done(bit s);
      if (s) m_seen = m_seen + 1;
      return s && (m_seen >= m_need);
   endfunction

   task automatic drive(bit s, bit e, bit h, bit r);
      bit es;
      sof        = s;
      enable     = e;
      boss_hit   = h;
      shot_ready = r;
      #1;
      es    = e && resetN && (m_ph == M_FIRE) && r;
      exp_v = {es, es && (m_shots == 0), m_ph == M_CHG,
               m_axis, 3'(m_shots)};
   endtask

   task automatic tick();
      logic [15:0] old;
      old = m_lfsr;
      if (!resetN) begin
         m_reset();
      end else begin
         if (!enable) begin
            m_ph    = M_IDLE;
            m_shots = 0;
         end else begin
            case (m_ph)
               M_IDLE: m_enter(M_COOL, cool_frames(old));
               M_COOL:
                  if (frame_done(sof)) m_enter(M_CHG, CF);
               M_CHG:
                  if (boss_hit) m_enter(M_COOL, cool_frames(old));
                  else if (frame_done(sof)) m_enter(M_FIRE, 0);
               M_FIRE:
                  if (shot_ready) begin
                     if (m_shots == 0) m_axis = old[0];
                     m_shots = m_shots + 1;
                     if (m_shots == BL) begin
                        m_shots = 0;
                        m_enter(M_COOL, cool_frames(old));
                     end else begin
                        m_enter(M_GAP, GAPF);
                     end
                  end
               M_GAP:
                  if (frame_done(sof)) m_enter(M_FIRE, 0);
               default: m_ph = M_IDLE;
            endcase
         end
         if (sof) m_lfsr = lfsr_step(old);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         drive(i[0], 1'b1, 1'b0, 1'b1);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL reset_outs got=%b want=%b", obs_v, exp_v);
         end
         total++;
         if (dut.lfsr !== SEED) begin
            bad++;
            $display("FAIL reset_lfsr got=%h want=%h", dut.lfsr, SEED);
         end
         tick();
      end
      resetN = 1'b1;
   endtask

   task automatic test_nominal();
      int  f      = 0;
      int  shots  = 0;
      int  sws    = 0;
      int  n      = 0;
      int  need_c = cool_frames(SEED);
      bit  s;
      bit  prev_ch = 1'b0;
      bit  done    = 1'b0;
      while (!done && n < 600) begin
         s = (n % 2 == 1);
         drive(s, 1'b1, 1'b0, 1'b1);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL nominal n=%0d got=%b want=%b", n, obs_v, exp_v);
         end
         if (charging && !prev_ch) begin
            total++;
            if (f !== need_c) begin
               bad++;
               $display("FAIL cool_len got=%0d want=%0d", f, need_c);
            end
            f = 0;
         end
         prev_ch = charging;
         if (shot_pulse) begin
            total++;
            if (f !== ((shots == 0) ? CF : GAPF)) begin
               bad++;
               $display("FAIL shot_spacing shot=%0d got=%0d want=%0d",
                        shots, f, (shots == 0) ? CF : GAPF);
            end
            f     = 0;
            shots = shots + 1;
            sws   = sws + int'(switch_direction_pulse);
         end else if (s) begin
            f = f + 1;
         end
         if (shots == BL) done = 1'b1;
         tick();
         n++;
      end
      total++;
      if (shots !== BL) begin
         bad++;
         $display("FAIL burst_shots got=%0d want=%0d", shots, BL);
      end
      total++;
      if (sws !== 1) begin
         bad++;
         $display("FAIL burst_switch got=%0d want=1", sws);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      total++;
      if (burst_count !== 3'd0) begin
         bad++;
         $display("FAIL burst_clear got=%0d want=0", burst_count);
      end
      tick();
   endtask

   task automatic test_stall();
      int n = 0;
      while (m_ph != M_FIRE && n < 800) begin
         drive(n[0], 1'b1, 1'b0, 1'b0);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL stall_pre got=%b want=%b", obs_v, exp_v);
         end
         tick();
         n++;
      end
      total++;
      if (m_ph != M_FIRE) begin
         bad++;
         $display("FAIL stall_timeout got=%0d want=%0d", m_ph, M_FIRE);
      end
      for (int i = 0; i < 100; i++) begin
         drive(i[0], 1'b1, 1'b0, 1'b0);
         total++;
         if (obs_v !== exp_v || shot_pulse !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold got=%b want=%b", obs_v, exp_v);
         end
         tick();
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      total++;
      if (obs_v !== exp_v || shot_pulse !== 1'b1) begin
         bad++;
         $display("FAIL stall_release got=%b want=%b", obs_v, exp_v);
      end
      tick();
   endtask

   task automatic test_hit_abort();
      int n    = 0;
      int nsh  = 0;
      while (!(m_ph == M_CHG && m_seen == 2) && n < 1200) begin
         drive(n[0], 1'b1, 1'b0, 1'b1);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL hit_pre got=%b want=%b", obs_v, exp_v);
         end
         tick();
         n++;
      end
      total++;
      if (m_ph != M_CHG) begin
         bad++;
         $display("FAIL hit_timeout got=%0d want=%0d", m_ph, M_CHG);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      total++;
      if (obs_v !== exp_v || charging !== 1'b1) begin
         bad++;
         $display("FAIL hit_cycle got=%b want=%b", obs_v, exp_v);
      end
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(i[0], 1'b1, 1'b0, 1'b1);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL hit_after got=%b want=%b", obs_v, exp_v);
         end
         nsh = nsh + int'(shot_pulse) + int'(charging);
         tick();
      end
      total++;
      if (nsh !== 0) begin
         bad++;
         $display("FAIL hit_no_shot got=%0d want=0", nsh);
      end
   endtask

   task automatic test_enable_drop();
      int n = 0;
      while (!(m_ph == M_FIRE && m_shots == 1) && n < 1200) begin
         drive(n[0], 1'b1, 1'b0, m_shots == 0);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL endrop_pre got=%b want=%b", obs_v, exp_v);
         end
         tick();
         n++;
      end
      total++;
      if (m_ph != M_FIRE) begin
         bad++;
         $display("FAIL endrop_timeout got=%0d want=%0d", m_ph, M_FIRE);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (obs_v !== exp_v || shot_pulse !== 1'b0) begin
         bad++;
         $display("FAIL endrop_shot got=%b want=%b", obs_v, exp_v);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (obs_v !== exp_v || burst_count !== 3'd0) begin
         bad++;
         $display("FAIL endrop_idle got=%b want=%b", obs_v, exp_v);
      end
      tick();
   endtask

   task automatic test_reset_mid_gap();
      int n   = 0;
      int nsh = 0;
      while (m_ph != M_GAP && n < 1200) begin
         drive(n[0], 1'b1, 1'b0, 1'b1);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL rstgap_pre got=%b want=%b", obs_v, exp_v);
         end
         tick();
         n++;
      end
      total++;
      if (m_ph != M_GAP) begin
         bad++;
         $display("FAIL rstgap_timeout got=%0d want=%0d", m_ph, M_GAP);
      end
      resetN = 1'b0;
      #1;
      m_reset();
      total++;
      if (obs_v !== 7'd0) begin
         bad++;
         $display("FAIL rstgap_async got=%b want=0000000", obs_v);
      end
      total++;
      if (dut.lfsr !== SEED) begin
         bad++;
         $display("FAIL rstgap_lfsr got=%h want=%h", dut.lfsr, SEED);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL rstgap_hold got=%b want=%b", obs_v, exp_v);
         end
         tick();
      end
      resetN = 1'b1;
      for (int i = 0; i < 30; i++) begin
         drive(i[0], 1'b1, 1'b0, 1'b1);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL rstgap_after got=%b want=%b", obs_v, exp_v);
         end
         nsh = nsh + int'(shot_pulse);
         tick();
      end
      total++;
      if (nsh !== 0) begin
         bad++;
         $display("FAIL rstgap_no_shot got=%0d want=0", nsh);
      end
   endtask

   task automatic test_random();
      bit s, e, h, r;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) resetN = 1'b0;
         else if (!resetN && $urandom_range(0, 3) == 0) resetN = 1'b1;
         s = ($urandom_range(0, 1) == 0);
         e = ($urandom_range(0, 79) != 0);
         h = ($urandom_range(0, 7) == 0);
         r = ($urandom_range(0, 3) != 0);
         drive(s, e, h, r);
         total++;
         if (obs_v !== exp_v) begin
            bad++;
            $display("FAIL random i=%0d got=%b want=%b", i, obs_v, exp_v);
         end
         tick();
      end
      resetN = 1'b1;
   endtask

   initial begin
      resetN     = 1'b0;
      sof        = 1'b0;
      enable     = 1'b0;
      boss_hit   = 1'b0;
      shot_ready = 1'b0;
      m_reset();
      @(negedge clk);
      test_reset();
      test_nominal();
      test_stall();
      test_hit_abort();
      test_enable_drop();
      test_reset_mid_gap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
